lut_frame_tx: RTL

- Downstream consumer of the 16-entry truth-table LUT stage.
- On a `start` pulse it snapshots the LUT's 16-bit RAM contents and streams them out LSB-first (address 0 first), one bit per beat, over a valid/ready handshake.
- While streaming it accumulates a ones-count, and it signals frame completion with a one-cycle `done` pulse.
- It sits between the LUT storage and any serial sink (debug port, checker, scan chain).

---
 rtl/lut_pkg.sv | 18 +
 rtl/lut_frame_tx_if.sv | 28 ++
 rtl/lut_frame_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lut_pkg.sv
// Shared definitions for the LUT storage stage and the LUT frame transmitter.
// The parity state exists only when LUT_FRAME_PARITY_EN is defined.
package lut_pkg;

  localparam int LUT_DEPTH  = 16;
  localparam int LUT_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
`ifdef LUT_FRAME_PARITY_EN
    ,
    ST_PAR  = 2'd3
`endif
  } lut_frame_state_t;

endpackage

// File: rtl/lut_frame_tx_if.sv
// Serial beat channel from the LUT frame transmitter to a bit-serial sink.
// The master presents a beat; the slave accepts it with tx_ready.
interface lut_frame_tx_if;
  import lut_pkg::*;

  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_bit;
  logic [LUT_ADDR_W-1:0] tx_idx;
  logic                  tx_last;

  modport master (
    output tx_valid,
    output tx_bit,
    output tx_idx,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_bit,
    input  tx_idx,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/lut_frame_tx.sv
// LUT frame transmitter: snapshots the LUT contents on start and streams them
// LSB-first, one bit per accepted beat, counting the ones that were accepted.
// Optional feature macro: LUT_FRAME_PARITY_EN appends an even-parity beat.
module lut_frame_tx
  import lut_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] ram_in,
  input  logic             start,
  output logic             busy,
  lut_frame_tx_if.master   tx,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             done
);

  localparam logic [LUT_ADDR_W-1:0] LAST_IDX = LUT_ADDR_W'(DEPTH - 1);

  lut_frame_state_t        r_state;
  lut_frame_state_t        w_next_state;
  logic [DEPTH-1:0]        r_snap;
  logic [LUT_ADDR_W-1:0]   r_idx;
  logic [CNT_W-1:0]        r_ones;

  logic                    w_ready;
  logic                    w_valid;
  logic                    w_bit;
  logic [LUT_ADDR_W-1:0]   w_idx;
  logic                    w_last;
  logic                    w_busy;
  logic                    w_done;
  logic                    w_capture;
  logic                    w_accept;
  logic [DEPTH-1:0]        w_sel_vec;
  logic                    w_sel_bit;

  assign w_ready = tx.tx_ready;

  // One-hot select of the snapshot bit addressed by the current index.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign w_sel_vec[gi] = r_snap[gi] & (r_idx == LUT_ADDR_W'(gi));
  end
  assign w_sel_bit = |w_sel_vec;

`ifdef LUT_FRAME_PARITY_EN
  logic w_parity;
  assign w_parity = ^r_snap;
`endif

  // FSM state register; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and beat outputs; idx/ones only advance on data-beat acceptance.
  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_bit        = 1'b0;
    w_idx        = '0;
    w_last       = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_capture    = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        w_valid  = 1'b1;
        w_bit    = w_sel_bit;
        w_idx    = r_idx;
`ifndef LUT_FRAME_PARITY_EN
        w_last   = (r_idx == LAST_IDX);
`endif
        w_accept = w_ready;
        if (w_ready && (r_idx == LAST_IDX)) begin
`ifdef LUT_FRAME_PARITY_EN
          w_next_state = ST_PAR;
`else
          w_next_state = ST_DONE;
`endif
        end
      end
`ifdef LUT_FRAME_PARITY_EN
      ST_PAR: begin
        w_valid = 1'b1;
        w_bit   = w_parity;
        w_last  = 1'b1;
        if (w_ready) begin
          w_next_state = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Snapshot, index and ones-count; the count holds after the frame until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_ones <= '0;
    end else if (w_capture) begin
      r_snap <= ram_in;
      r_idx  <= '0;
      r_ones <= '0;
    end else if (w_accept) begin
      r_idx  <= r_idx + LUT_ADDR_W'(1);
      r_ones <= r_ones + CNT_W'(w_sel_bit);
    end
  end

  assign tx.tx_valid = w_valid;
  assign tx.tx_bit   = w_bit;
  assign tx.tx_idx   = w_idx;
  assign tx.tx_last  = w_last;
  assign busy        = w_busy;
  assign done        = w_done;
  assign ones_cnt    = r_ones;

endmodule
